draw_arbiter: RTL and testbench

DRAW_ARBITER -- requirements
Module: draw_arbiter

---
 rtl/draw_arbiter.sv | 159 +++++++++++++++
 tb/tb_draw_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/draw_arbiter.sv
// Round-robin arbiter that gives one of three requesters the sprite drawer,
// latches its coordinates, and guards each draw with a watchdog.
//   state   | meaning
//   IDLE    | no owner; pick a winner when any req is high
//   ISSUE   | one-cycle drawStart pulse to the drawer
//   BUSY    | wait for drawDone or a watchdog expiry
//   RELEASE | one-cycle done pulse to the owner, then back to IDLE
module draw_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd2_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [26:0] reqX,
  input  logic [23:0] reqY,
  input  logic [5:0]  reqSprite,
  input  logic        drawDone,
  output logic        drawStart,
  output logic [8:0]  drawX,
  output logic [7:0]  drawY,
  output logic [1:0]  drawSprite,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic        busy,
  output logic        timeoutErr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RELEASE
  } state_t;

  state_t      state_q;
  logic        draw_start_q;
  logic [8:0]  draw_x_q;
  logic [7:0]  draw_y_q;
  logic [1:0]  draw_sprite_q;
  logic [2:0]  grant_q;
  logic [2:0]  done_q;
  logic        busy_q;
  logic        timeout_err_q;
  logic [23:0] count_q;
  logic [1:0]  last_q;
  logic [1:0]  owner_q;

  logic [1:0]  win_d;
  logic [2:0]  win_onehot_d;
  logic [8:0]  win_x_d;
  logic [7:0]  win_y_d;
  logic [1:0]  win_sprite_d;
  logic        count_hit;

  // Search starts one past the previous owner and wraps around.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] s0, s1, s2;
    case (last)
      2'd0:    begin s0 = 2'd1; s1 = 2'd2; s2 = 2'd0; end
      2'd1:    begin s0 = 2'd2; s1 = 2'd0; s2 = 2'd1; end
      default: begin s0 = 2'd0; s1 = 2'd1; s2 = 2'd2; end
    endcase
    if (r[s0])      rr_pick = s0;
    else if (r[s1]) rr_pick = s1;
    else            rr_pick = s2;
  endfunction

  always_comb begin
    win_d        = rr_pick(req, last_q);
    win_onehot_d = 3'b001;
    win_x_d      = reqX[8:0];
    win_y_d      = reqY[7:0];
    win_sprite_d = reqSprite[1:0];
    case (win_d)
      2'd1: begin
        win_onehot_d = 3'b010;
        win_x_d      = reqX[17:9];
        win_y_d      = reqY[15:8];
        win_sprite_d = reqSprite[3:2];
      end
      2'd2: begin
        win_onehot_d = 3'b100;
        win_x_d      = reqX[26:18];
        win_y_d      = reqY[23:16];
        win_sprite_d = reqSprite[5:4];
      end
      default: ;
    endcase
  end

  assign count_hit = (count_q == (TIMEOUT - 24'd1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      draw_start_q  <= 1'b0;
      draw_x_q      <= '0;
      draw_y_q      <= '0;
      draw_sprite_q <= '0;
      grant_q       <= '0;
      done_q        <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      count_q       <= '0;
      last_q        <= 2'd2;
      owner_q       <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            state_q       <= S_ISSUE;
            owner_q       <= win_d;
            grant_q       <= win_onehot_d;
            draw_x_q      <= win_x_d;
            draw_y_q      <= win_y_d;
            draw_sprite_q <= win_sprite_d;
            draw_start_q  <= 1'b1;
            busy_q        <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_q      <= S_BUSY;
          draw_start_q <= 1'b0;
          count_q      <= '0;
        end
        S_BUSY: begin
          if (drawDone) begin
            state_q <= S_RELEASE;
            done_q  <= grant_q;
          end else if (count_hit) begin
            state_q       <= S_RELEASE;
            done_q        <= grant_q;
            timeout_err_q <= 1'b1;
          end else if (count_q != 24'hFF_FFFF) begin
            count_q <= count_q + 24'd1;
          end
        end
        S_RELEASE: begin
          state_q <= S_IDLE;
          done_q  <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          last_q  <= owner_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign drawStart  = draw_start_q;
  assign drawX      = draw_x_q;
  assign drawY      = draw_y_q;
  assign drawSprite = draw_sprite_q;
  assign grant      = grant_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign timeoutErr = timeout_err_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter: a table of arbitrated transactions plus
// hand-written watchdog, stability, stray-done and mid-transaction reset sequences.
module tb_draw_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [26:0] reqX;
  logic [23:0] reqY;
  logic [5:0]  reqSprite;
  logic        drawDone;
  logic        drawStart;
  logic [8:0]  drawX;
  logic [7:0]  drawY;
  logic [1:0]  drawSprite;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic        timeoutErr;

  int n_tests = 0;
  int n_fail  = 0;

  draw_arbiter #(.TIMEOUT(24'd8)) dut (
    .clock(clock), .reset(reset), .req(req), .reqX(reqX), .reqY(reqY),
    .reqSprite(reqSprite), .drawDone(drawDone), .drawStart(drawStart),
    .drawX(drawX), .drawY(drawY), .drawSprite(drawSprite), .grant(grant),
    .done(done), .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ld;
    logic [2:0]  req;
    logic [26:0] x;
    logic [23:0] y;
    logic [5:0]  sp;
    int          delay;
    int          drop;   // 0 keep req, 1 owner drops its bit, 2 clear all
    logic [2:0]  eg;
    logic [8:0]  ex;
    logic [7:0]  ey;
    logic [1:0]  es;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(logic ld, logic [2:0] r, logic [26:0] x, logic [23:0] y,
                              logic [5:0] sp, int delay, int drop, logic [2:0] eg,
                              logic [8:0] ex, logic [7:0] ey, logic [1:0] es);
    vec_t v;
    v.ld = ld; v.req = r; v.x = x; v.y = y; v.sp = sp; v.delay = delay; v.drop = drop;
    v.eg = eg; v.ex = ex; v.ey = ey; v.es = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = mk(1, 3'b111, {9'd300, 9'd200, 9'd100}, {8'd30, 8'd20, 8'd10}, {2'd3, 2'd2, 2'd1},
                 1, 1, 3'b001, 9'd100, 8'd10, 2'd1);
    vecs[1] = mk(0, 3'b000, '0, '0, '0, 2, 1, 3'b010, 9'd200, 8'd20, 2'd2);
    vecs[2] = mk(0, 3'b000, '0, '0, '0, 5, 1, 3'b100, 9'd300, 8'd30, 2'd3);
    vecs[3] = mk(1, 3'b011, {9'd0, 9'd411, 9'd7}, {8'd0, 8'd99, 8'd1}, {2'd0, 2'd3, 2'd0},
                 1, 0, 3'b001, 9'd7, 8'd1, 2'd0);
    vecs[4] = mk(0, 3'b000, '0, '0, '0, 1, 0, 3'b010, 9'd411, 8'd99, 2'd3);
    vecs[5] = mk(0, 3'b000, '0, '0, '0, 2, 0, 3'b001, 9'd7, 8'd1, 2'd0);
    vecs[6] = mk(0, 3'b000, '0, '0, '0, 1, 2, 3'b010, 9'd411, 8'd99, 2'd3);
    vecs[7] = mk(1, 3'b001, {9'd0, 9'd0, 9'd95}, {8'd0, 8'd0, 8'd221}, {2'd0, 2'd0, 2'd1},
                 3, 1, 3'b001, 9'd95, 8'd221, 2'd1);
    vecs[8] = mk(1, 3'b110, {9'd511, 9'd256, 9'd0}, {8'd255, 8'd128, 8'd0}, {2'd2, 2'd1, 2'd0},
                 1, 1, 3'b010, 9'd256, 8'd128, 2'd1);
    vecs[9] = mk(0, 3'b000, '0, '0, '0, 4, 1, 3'b100, 9'd511, 8'd255, 2'd2);

    reset = 1'b1; req = '0; reqX = '0; reqY = '0; reqSprite = '0; drawDone = 1'b0;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_start", drawStart, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", drawX, 0);
    chk("rst_y", drawY, 0);
    chk("rst_sprite", drawSprite, 0);
    chk("rst_timeout", timeoutErr, 0);
    tick; tick;
    reset = 1'b0;
    tick;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].ld) begin
        req = vecs[i].req; reqX = vecs[i].x; reqY = vecs[i].y; reqSprite = vecs[i].sp;
      end
      tick;
      chk($sformatf("v%0d_start", i), drawStart, 1);
      chk($sformatf("v%0d_grant", i), grant, vecs[i].eg);
      chk($sformatf("v%0d_x", i), drawX, vecs[i].ex);
      chk($sformatf("v%0d_y", i), drawY, vecs[i].ey);
      chk($sformatf("v%0d_sprite", i), drawSprite, vecs[i].es);
      chk($sformatf("v%0d_busy", i), busy, 1);
      chk($sformatf("v%0d_done_early", i), done, 0);
      tick;
      chk($sformatf("v%0d_start_once", i), drawStart, 0);
      repeat (vecs[i].delay - 1) tick;
      drawDone = 1'b1;
      tick;
      drawDone = 1'b0;
      chk($sformatf("v%0d_done", i), done, vecs[i].eg);
      chk($sformatf("v%0d_grant_rel", i), grant, vecs[i].eg);
      chk($sformatf("v%0d_start_rel", i), drawStart, 0);
      tick;
      chk($sformatf("v%0d_done_clr", i), done, 0);
      chk($sformatf("v%0d_grant_clr", i), grant, 0);
      chk($sformatf("v%0d_busy_clr", i), busy, 0);
      if (vecs[i].drop == 1) req = req & ~vecs[i].eg;
      else if (vecs[i].drop == 2) req = '0;
    end

    // Watchdog with TIMEOUT=8: BUSY cycles t0+1..t0+8, error visible at t0+9.
    req = 3'b100; reqX = {9'd12, 18'd0};
    tick;
    chk("wd_start", drawStart, 1);
    chk("wd_grant", grant, 3'b100);
    repeat (8) tick;
    chk("wd_err_before", timeoutErr, 0);
    chk("wd_done_before", done, 0);
    chk("wd_busy", busy, 1);
    tick;
    chk("wd_err", timeoutErr, 1);
    chk("wd_done", done, 3'b100);
    tick;
    req = '0;
    chk("wd_done_once", done, 0);
    chk("wd_grant_clr", grant, 0);
    req = 3'b001;
    tick;
    chk("wd2_grant", grant, 3'b001);
    tick;
    drawDone = 1'b1;
    tick;
    drawDone = 1'b0;
    chk("wd2_done", done, 3'b001);
    chk("wd2_err_sticky", timeoutErr, 1);
    tick;
    req = '0;
    chk("wd2_err_sticky2", timeoutErr, 1);

    // Latched fields stay put while req/reqX change under an active grant.
    req = 3'b010; reqX = {9'd0, 9'd77, 9'd0}; reqY = {8'd0, 8'd66, 8'd0}; reqSprite = 6'b00_10_00;
    tick;
    chk("stab_grant", grant, 3'b010);
    chk("stab_x", drawX, 77);
    tick;
    reqX = {9'd0, 9'd5, 9'd0}; reqY = {8'd0, 8'd3, 8'd0}; req = '0;
    tick;
    chk("stab_x_busy", drawX, 77);
    chk("stab_y_busy", drawY, 66);
    chk("stab_grant_busy", grant, 3'b010);
    chk("stab_busy", busy, 1);
    drawDone = 1'b1;
    tick;
    drawDone = 1'b0;
    chk("stab_done", done, 3'b010);
    chk("stab_x_rel", drawX, 77);
    tick;
    chk("stab_done_clr", done, 0);
    chk("stab_busy_clr", busy, 0);

    drawDone = 1'b1;
    tick;
    drawDone = 1'b0;
    chk("stray_done", done, 0);
    chk("stray_busy", busy, 0);
    chk("stray_grant", grant, 0);
    chk("stray_start", drawStart, 0);
    tick;
    chk("stray_done2", done, 0);
    chk("stray_busy2", busy, 0);

    // Reset between edges while BUSY.
    req = 3'b001;
    tick;
    tick;
    chk("mid_busy_pre", busy, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_grant", grant, 0);
    chk("mid_busy", busy, 0);
    chk("mid_start", drawStart, 0);
    chk("mid_err_clr", timeoutErr, 0);
    chk("mid_x", drawX, 0);
    req = '0;
    tick;
    reset = 1'b0;
    drawDone = 1'b1;
    tick;
    drawDone = 1'b0;
    chk("mid_no_done", done, 0);
    chk("mid_no_busy", busy, 0);
    tick;
    chk("mid_no_done2", done, 0);
    chk("mid_grant2", grant, 0);

    req = 3'b111;
    tick;
    chk("post_rst_rr", grant, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
